updi_frame_gen: RTL
===================

# updi_frame_gen

Parametrised UPDI character generator, successor to the fixed CG_FSM. It accepts one command (opcode, repeat count, direction), then emits the full frame stream toward the PHY TX serializer: SYNCH, optional REPEAT prologue, instruction, then application payload. Unlike CG_FSM, it supports output back-pressure from the PHY, configurable stop bits, configurable bytes per operation, and a load (header-only) mode. It sits between the APP data source and the PHY TX memory.

## Interface
Parameters:
- STOP_BITS, 2: stop bits per frame, legal values 1..2.
- BYTES_PER_OP, 4: payload bytes per instruction execution, legal values 1..4.
- FRAME_W, 9+1+STOP_BITS: localparam, derived; not overridable.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_opcode  in  8  instruction character (e.g. ST 0x64).
- i_cmd_repeat  in  8  REPEAT count; 0 means no REPEAT prologue.
- i_cmd_ld  in  1  1 = load mode: header only, no payload.
- i_valid  in  1  payload byte valid.
- i_data  in  8  payload byte.
- o_ready  out  1  payload byte accepted when high with i_valid.
- o_valid  out  1  o_data holds a frame.
- i_ready  in  1  PHY accepts the frame.
- o_data  out  FRAME_W  frame.
- o_busy  out  1  high from command accept through o_done.
- o_done  out  1  one-cycle pulse at end of transaction.

## Operation
- Frame layout, MSB first:
  - o_data[FRAME_W-1] = start bit 0.
  - o_data[FRAME_W-2 -: 8] = character.
  - o_data[STOP_BITS] = even parity, i.e. ^character.
  - o_data[STOP_BITS-1:0] = all ones.
- States: IDLE, SYNC0, RPT_OP, RPT_CNT, SYNC1, INSTR, DATA, DONE.
- IDLE:
  - o_cmd_ready=1.
  - On accept, latch opcode, repeat and ld, then go to SYNC0.
  - Payload count N = (repeat+1)*BYTES_PER_OP. The counter is wide enough for 256*BYTES_PER_OP; there is no wrap.
- SYNC0 emits 0x55.
  - If repeat≠0: go to RPT_OP, which emits 0xA0; then RPT_CNT, which emits repeat; then SYNC1, which emits 0x55; then INSTR.
  - If repeat=0: go directly to INSTR.
- INSTR emits the opcode.
  - If ld=1: go to DONE after the handshake.
  - Otherwise: go to DATA.
- DATA:
  - o_ready = !o_valid || i_ready.
  - Each accepted byte is framed into the output register and decrements the counter.
  - After the handshake of the N-th payload frame, go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
- Header states advance only on an output handshake (o_valid && i_ready).
- A new command is not accepted until IDLE. i_valid outside DATA is ignored; o_ready=0 outside DATA.

## Timing
- Reset values (one cycle of i_rst): state=IDLE, o_valid=0, o_data=0, o_cmd_ready=1, o_ready=0, o_busy=0, o_done=0, counter=0.
- Reset mid-transaction:
  - Abandon immediately. Any frame in the output register is dropped.
  - No o_done pulse.
  - Accepted but unsent payload is lost.
- Latency:
  - Command accept at cycle T gives SYNC0 frame valid at T+1.
  - Payload byte accepted at T appears on o_data at T+1.
- Output register is single-entry.
  - o_valid and o_data are held stable while i_ready=0.
  - On a handshake, the next frame loads in the same edge, so o_valid stays high and throughput is 1 frame/cycle.
- With i_ready held high and i_valid held high, a ST with repeat=r takes 5 (r≠0) or 2 (r=0) header cycles plus N payload cycles, then DONE.
- Simultaneous i_valid and a pending-frame stall: the byte is not accepted. o_ready is the only acceptance condition.

## Structure
- Shared package updi_pkg:
  - Constants SYNCH_CHAR=8'h55 and OPC_REPEAT=8'hA0.
  - State enum.
  - Function make_frame(char, stop_bits) returning the start/char/parity/stop frame.
- No sub-module. A single FSM, the payload counter and the output register live in updi_frame_gen.

## Test plan
- Reset, then command opcode=0x64, repeat=0, ld=0, BYTES_PER_OP=4, i_ready=1:
  - Frames 0_01010101_0_11, then 0_01100100_1_11, then 4 payload frames with correct parity.
  - o_done asserts once; 6 frames total.
- Command repeat=10 with random payload, i_ready=1:
  - Frames SYNCH, 0_10100000_0_11, 0_00001010_0_11, SYNCH, 0x64, then 44 payload frames matching input order; o_done.
- Same command as the previous scenario, with i_ready toggled pseudo-randomly:
  - o_data is stable while o_valid && !i_ready.
  - No byte is lost or duplicated; frame count is 49.
- ld=1, repeat=2, opcode=0x24:
  - 5 header frames only; o_ready never asserts; o_done follows the 0x24 handshake.
- STOP_BITS=1 build, payload 0xFF:
  - Frame 0_11111111_0_1, FRAME_W=11.
- i_rst asserted during DATA with o_valid=1:
  - Next cycle o_valid=0, o_busy=0, o_cmd_ready=1, no o_done.
  - A following command starts cleanly with SYNCH.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared UPDI character constants, generator state encoding and frame builder.
// Frames are returned right-aligned in a 12-bit vector; 1-stop-bit frames leave bit 11 at zero.
package updi_pkg;

   localparam logic [7:0] SYNCH_CHAR = 8'h55;
   localparam logic [7:0] OPC_REPEAT = 8'hA0;
   localparam int         FRAME_MAX  = 12;

   typedef enum logic [2:0] {
      IDLE,
      SYNC0,
      RPT_OP,
      RPT_CNT,
      SYNC1,
      INSTR,
      DATA,
      DONE
   } state_t;

   // start bit, character MSB first, even parity, then stop bits
   function automatic logic [FRAME_MAX-1:0] make_frame(input logic [7:0] ch, input int stop_bits);
      logic [FRAME_MAX-1:0] f;
      if (stop_bits == 1) f = {1'b0, 1'b0, ch, ^ch, 1'b1};
      else                f = {1'b0, ch, ^ch, 2'b11};
      return f;
   endfunction

endpackage

// File: rtl/updi_frame_gen.sv
// UPDI frame stream generator: SYNCH, optional REPEAT prologue, instruction, then payload.
// Single-entry output register; one frame per cycle when the PHY keeps i_ready high.
module updi_frame_gen
   import updi_pkg::*;
#(
   parameter  int STOP_BITS    = 2,
   parameter  int BYTES_PER_OP = 4,
   localparam int FRAME_W      = 9 + 1 + STOP_BITS
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [7:0]         i_cmd_opcode,
   input  logic [7:0]         i_cmd_repeat,
   input  logic               i_cmd_ld,
   input  logic               i_valid,
   input  logic [7:0]         i_data,
   output logic               o_ready,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [FRAME_W-1:0] o_data,
   output logic               o_busy,
   output logic               o_done
);

   // sized so (255+1)*BYTES_PER_OP fits without wrapping
   localparam int CNT_W = $clog2(256 * BYTES_PER_OP + 1);

   state_t           state;
   logic [7:0]       opc;
   logic [7:0]       rpt;
   logic             ld;
   logic [CNT_W-1:0] cnt;
   logic             out_hs;
   logic             in_hs;

   function automatic logic [FRAME_W-1:0] frm(input logic [7:0] ch);
      logic [FRAME_MAX-1:0] f;
      f = make_frame(ch, STOP_BITS);
      return f[FRAME_W-1:0];
   endfunction

   assign out_hs      = o_valid && i_ready;
   assign in_hs       = o_ready && i_valid;
   assign o_cmd_ready = (state == IDLE);
   assign o_ready     = (state == DATA) && (cnt != '0) && (!o_valid || i_ready);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         cnt     <= '0;
         opc     <= '0;
         rpt     <= '0;
         ld      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_cmd_valid) begin
                  opc     <= i_cmd_opcode;
                  rpt     <= i_cmd_repeat;
                  ld      <= i_cmd_ld;
                  cnt     <= (CNT_W'(i_cmd_repeat) + CNT_W'(1)) * CNT_W'(BYTES_PER_OP);
                  o_valid <= 1'b1;
                  o_data  <= frm(SYNCH_CHAR);
                  o_busy  <= 1'b1;
                  state   <= SYNC0;
               end
            end
            SYNC0: begin
               if (out_hs) begin
                  if (rpt != 8'd0) begin
                     o_data <= frm(OPC_REPEAT);
                     state  <= RPT_OP;
                  end else begin
                     o_data <= frm(opc);
                     state  <= INSTR;
                  end
               end
            end
            RPT_OP: begin
               if (out_hs) begin
                  o_data <= frm(rpt);
                  state  <= RPT_CNT;
               end
            end
            RPT_CNT: begin
               if (out_hs) begin
                  o_data <= frm(SYNCH_CHAR);
                  state  <= SYNC1;
               end
            end
            SYNC1: begin
               if (out_hs) begin
                  o_data <= frm(opc);
                  state  <= INSTR;
               end
            end
            INSTR: begin
               if (out_hs) begin
                  o_valid <= 1'b0;
                  if (ld) begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= DONE;
                  end else begin
                     state  <= DATA;
                  end
               end
            end
            DATA: begin
               // a new byte replaces the frame leaving on this edge, keeping o_valid high
               if (in_hs) begin
                  o_valid <= 1'b1;
                  o_data  <= frm(i_data);
                  cnt     <= cnt - CNT_W'(1);
               end else if (out_hs) begin
                  o_valid <= 1'b0;
               end
               if (out_hs && cnt == '0) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
